pipeline_hazard_ctrl: RTL

- Pipeline controller for the decode stage: a scoreboard of in-flight destination registers and a redirect/flush FSM.
- Generates the data-hazard stall into decode (decode injects a NOP while it is asserted).
- Generates fetch hold, the fetch/decode flush strobes and the PC source select for jumps resolved in ID and taken branches resolved in EX.
- Sits between fetch, decode and execute. No forwarding network; all RAW hazards are resolved by stalling.

---
 rtl/pipeline_hazard_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: decode-stage scoreboard stall plus redirect/flush FSM
module pipeline_hazard_ctrl #(
  parameter int SB_DEPTH     = 3,
  parameter int WB_BYPASS    = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_wb_we,
  input  logic        id_jump,
  input  logic        ex_branch_taken,
  output logic        stall_data_hazard,
  output logic        stall_fetch,
  output logic        flush_fetch,
  output logic        flush_decode,
  output logic [1:0]  pc_sel,
  output logic [31:0] busy_mask,
  output logic [15:0] stall_count
);
  localparam int HZ_N = SB_DEPTH - WB_BYPASS;
  typedef enum logic {RUN, SQUASH} state_t;
  state_t            state;
  logic [1:0]        cnt;
  logic [SB_DEPTH-1:0] sb_valid;
  logic [4:0]        sb_rd [SB_DEPTH];
  logic              m1, m2, in_sq, squash, hz, jmp, ins;
  // compare decode sources against entries that have not yet reached writeback
  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    for (int i = 0; i < HZ_N; i++) begin
      m1 = m1 | (sb_valid[i] & (sb_rd[i] == id_rs1));
      m2 = m2 | (sb_valid[i] & (sb_rd[i] == id_rs2));
    end
  end
  assign in_sq  = (state == SQUASH);
  assign squash = in_sq | ex_branch_taken;
  assign hz     = id_valid & ~squash &
                  ((id_rs1_used & (id_rs1 != 5'd0) & m1) | (id_rs2_used & (id_rs2 != 5'd0) & m2));
  assign jmp    = id_valid & id_jump & ~squash & ~hz;
  assign ins    = id_valid & ~hz & ~squash & id_wb_we & (id_rd != 5'd0);
  assign stall_data_hazard = hz;
  assign stall_fetch       = hz;
  assign flush_decode      = squash;
  assign flush_fetch       = ex_branch_taken | jmp;
  assign pc_sel = ex_branch_taken ? 2'b10 : in_sq ? 2'b00 : hz ? 2'b11 : jmp ? 2'b01 : 2'b00;
  // pending-register view of every valid entry, writeback included
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < SB_DEPTH; i++)
      if (sb_valid[i]) busy_mask[sb_rd[i]] = 1'b1;
    busy_mask[0] = 1'b0;
  end
  // scoreboard advances every cycle; a stalled or squashed slot becomes a bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_valid <= '0;
      for (int i = 0; i < SB_DEPTH; i++) sb_rd[i] <= 5'd0;
    end else begin
      sb_valid <= {sb_valid[SB_DEPTH-2:0], ins};
      sb_rd[0] <= id_rd;
      for (int i = 1; i < SB_DEPTH; i++) sb_rd[i] <= sb_rd[i-1];
    end
  end
  // redirect FSM: a taken branch always (re)arms the squash window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else if (ex_branch_taken || (state == RUN && jmp)) begin
      state <= SQUASH;
      cnt   <= 2'(FLUSH_CYCLES);
    end else if (state == SQUASH) begin
      if (cnt == 2'd1) state <= RUN;
      else cnt <= cnt - 2'd1;
    end
  end
  // saturating hazard-stall counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_count <= 16'd0;
    else if (hz && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
endmodule
